// File: rtl/glitch_clk_multi.sv
// glitch_clk_multi: multi-mode target clock glitcher (fast cycles, dropped cycles, stretched high).
module glitch_clk_multi #(
    parameter int CNT_W       = 16,
    parameter int DLY_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             tgt_clk,
    input  logic [1:0]       cfg_mode,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [CNT_W-1:0] cfg_count,
    output logic             clk_o,
    output logic             busy,
    output logic             glitch_active,
    output logic             done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ARMED    = 3'd1;
    localparam logic [2:0] INJECT   = 3'd2;
    localparam logic [2:0] RECOVER  = 3'd3;
    localparam logic [2:0] FINISHED = 3'd4;
    localparam logic [1:0] M_FAST    = 2'd0;
    localparam logic [1:0] M_DROP    = 2'd1;
    localparam logic [1:0] M_STRETCH = 2'd2;

    logic [2:0]             state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   tgt_s, tgt_s_q, trig_q;
    logic                   tgt_rise, tgt_fall, trig_rise, len_last;
    logic [1:0]             mode_q;
    logic [DLY_W-1:0]       dly_q, dly_cnt;
    logic [CNT_W-1:0]       cnt_q, len_cnt;

    assign tgt_s     = sync[SYNC_STAGES-1];
    assign tgt_rise  = tgt_s & ~tgt_s_q;
    assign tgt_fall  = ~tgt_s & tgt_s_q;
    assign trig_rise = trig & ~trig_q;
    assign len_last  = len_cnt == cnt_q - CNT_W'(1);

    assign busy          = state == ARMED || state == INJECT || state == RECOVER;
    assign glitch_active = state == INJECT;

    // Raw tgt_clk is muxed so passthrough carries no synchroniser latency.
    always_comb begin
        clk_o = state == RECOVER ? 1'b0 :
                state != INJECT  ? tgt_clk :
                mode_q == M_FAST    ? clk :
                mode_q == M_DROP    ? 1'b0 :
                mode_q == M_STRETCH ? 1'b1 : tgt_clk;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sync    <= '0;
            tgt_s_q <= 1'b0;
            trig_q  <= 1'b1;
            mode_q  <= '0;
            dly_q   <= '0;
            cnt_q   <= '0;
            dly_cnt <= '0;
            len_cnt <= '0;
            done    <= 1'b0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], tgt_clk};
            tgt_s_q <= tgt_s;
            trig_q  <= trig;
            done    <= 1'b0;
            case (state)
                IDLE: if (trig_rise && cfg_count != '0) begin
                    mode_q  <= cfg_mode;
                    dly_q   <= cfg_delay;
                    cnt_q   <= cfg_count;
                    dly_cnt <= '0;
                    len_cnt <= '0;
                    state   <= ARMED;
                end
                ARMED: if (tgt_rise) begin
                    if (dly_cnt == dly_q) begin
                        len_cnt <= '0;
                        state   <= INJECT;
                    end else begin
                        dly_cnt <= dly_cnt + DLY_W'(1);
                    end
                end
                INJECT: begin
                    // DROP counts target edges; the other modes count clk cycles.
                    if (len_last) state <= RECOVER;
                    else if (mode_q != M_DROP || tgt_rise) len_cnt <= len_cnt + CNT_W'(1);
                end
                RECOVER: if (tgt_fall) begin
                    state <= FINISHED;
                    done  <= 1'b1;
                end
                FINISHED: if (!trig) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_glitch_clk_multi.sv
// tb_glitch_clk_multi: scoreboard bench; expected per-sequence results are queued, checked on done.
module tb_glitch_clk_multi;
    logic        clk = 1'b0, rst = 1'b1, trig = 1'b1, tgt_clk = 1'b0;
    logic [1:0]  cfg_mode = 2'd0;
    logic [15:0] cfg_delay = 16'd0, cfg_count = 16'd3;
    logic        clk_o, busy, glitch_active, done;

    typedef struct {int inj; int pre; int bad; bit low;} exp_t;
    exp_t q[$];
    int tests = 0, errors = 0;
    int inj_n = 0, pre_n = 0, bad_n = 0, pass_bad = 0;
    bit inj_seen = 0, prev_clko = 0;
    logic [1:0] cur_mode = 2'd0;

    glitch_clk_multi dut (
        .clk(clk), .rst(rst), .trig(trig), .tgt_clk(tgt_clk), .cfg_mode(cfg_mode),
        .cfg_delay(cfg_delay), .cfg_count(cfg_count), .clk_o(clk_o), .busy(busy),
        .glitch_active(glitch_active), .done(done)
    );

    always #5 clk = ~clk;
    // Target clock: 200 ns period (20 clk), phase offset from clk edges.
    initial begin
        #3;
        forever begin
            tgt_clk = 1'b1; #100;
            tgt_clk = 1'b0; #100;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulates per-sequence observations, compares against queue head on done.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (rst) begin
            inj_n = 0; pre_n = 0; bad_n = 0; inj_seen = 0;
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    tests++; errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("inject_cycles", inj_n, e.inj);
                    chk("pass_rises_before_inject", pre_n, e.pre);
                    chk("clk_o_shape_errors", bad_n, e.bad);
                    chk("low_phase_at_done", int'(clk_o == 1'b0 && tgt_clk == 1'b0), int'(e.low));
                end
                inj_n = 0; pre_n = 0; bad_n = 0; inj_seen = 0;
            end
            if (!busy && clk_o !== tgt_clk) pass_bad++;
            if (glitch_active) begin
                inj_n++;
                inj_seen = 1;
                if (clk_o !== (cur_mode != 2'd1)) bad_n++;
            end else if (busy && inj_seen) begin
                if (clk_o !== 1'b0) bad_n++;
            end else if (busy) begin
                if (clk_o !== tgt_clk) bad_n++;
                if (clk_o && !prev_clko) pre_n++;
            end
        end
        prev_clko = clk_o;
    end

    always @(negedge clk) begin
        #1;
        if (!rst && glitch_active && clk_o !== (cur_mode == 2'd2)) bad_n++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [1:0] m, input int d, input int c);
        @(negedge tgt_clk);
        repeat (3) tick();
        cur_mode  = m;
        cfg_mode  = m;
        cfg_delay = 16'(d);
        cfg_count = 16'(c);
        trig      = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (q.size() != 0 && n < 3000) begin
            tick();
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: got no done in %0d clk, expected done", name, n);
            q.delete();
        end
    endtask

    initial begin
        int act, n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", int'(busy), 0);
        chk("reset_glitch_active", int'(glitch_active), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_clk_o_pass", int'(clk_o), int'(tgt_clk));
        // trig high through reset release must not arm
        act = 0;
        repeat (30) begin tick(); act += int'(busy); end
        chk("trig_high_at_reset_no_arm", act, 0);
        trig = 1'b0;
        tick();

        start(2'd0, 0, 3);
        q.push_back('{3, 1, 0, 1'b1});
        wait_done("fast");
        trig = 1'b0;
        repeat (3) tick();
        chk("fast_busy_after", int'(busy), 0);

        start(2'd1, 2, 2);
        q.push_back('{21, 3, 0, 1'b1});
        repeat (2) tick();
        cfg_mode = 2'd3; cfg_count = 16'd1; cfg_delay = 16'd0;
        wait_done("drop");
        trig = 1'b0;
        repeat (3) tick();

        start(2'd2, 1, 5);
        q.push_back('{5, 2, 0, 1'b1});
        wait_done("stretch");
        trig = 1'b0;
        repeat (3) tick();

        start(2'd0, 0, 0);
        act = 0;
        repeat (60) begin tick(); act += int'(busy | glitch_active | done); end
        trig = 1'b0;
        chk("count0_stays_idle", act, 0);
        chk("count0_passthrough_errors", pass_bad, 0);

        start(2'd0, 0, 100);
        n = 0;
        while (!glitch_active && n < 500) begin tick(); n++; end
        chk("reach_inject_before_reset", int'(glitch_active), 1);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_glitch_active", int'(glitch_active), 0);
        chk("midreset_clk_o_pass", int'(clk_o), int'(tgt_clk));
        repeat (30) tick();
        trig = 1'b0;
        tick();
        start(2'd0, 0, 4);
        q.push_back('{4, 1, 0, 1'b1});
        wait_done("after_reset");
        trig = 1'b0;
        repeat (3) tick();

        start(2'd0, 1, 2);
        q.push_back('{2, 2, 0, 1'b1});
        wait_done("held_trig");
        act = 0;
        repeat (200) begin tick(); act += int'(busy | glitch_active); end
        chk("held_trig_no_rearm", act, 0);
        trig = 1'b0;
        repeat (2) tick();
        start(2'd2, 0, 3);
        q.push_back('{3, 1, 0, 1'b1});
        wait_done("second_seq");
        trig = 1'b0;
        repeat (5) tick();
        chk("final_passthrough_errors", pass_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/glitch_clk_multi.md
Name: glitch_clk_multi

Overview:
- Multi-mode clock glitch generator; successor to the single-mode fast-cycle injector.
- Sits between the clean target clock source and the target clock pin.
- Three run-time modes:
  - FAST: inject fast system-clock cycles.
  - DROP: suppress whole target cycles.
  - STRETCH: hold the target clock high.
- Each mode has a programmable delay, counted in target clock cycles after the trigger, and a programmable length. The one-shot handshake requires trig to go low before the block re-arms.

Parameters:
- CNT_W, 16, width of cfg_count and the internal length counter.
- DLY_W, 16, width of cfg_delay and the internal delay counter.
- SYNC_STAGES, 2, flip-flop stages synchronising tgt_clk into the clk domain (minimum 2).

Ports:
- clk  in  1  fast system clock; all state is clocked on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- trig  in  1  glitch request; the rising edge arms the block.
- tgt_clk  in  1  clean target clock; asynchronous to clk and slower than clk/4.
- cfg_mode  in  2  0=FAST, 1=DROP, 2=STRETCH, 3=NONE.
- cfg_delay  in  DLY_W  target rising edges to skip before glitching.
- cfg_count  in  CNT_W  glitch length; 0 means disabled.
- clk_o  out  1  clock driven to the target.
- busy  out  1  high in ARMED, INJECT and RECOVER.
- glitch_active  out  1  high in INJECT.
- done  out  1  one-clk pulse when the sequence completes.

Behaviour:
- Reset values: state=IDLE; delay and length counters=0; synchroniser=0; trig_q=1 (suppresses a spurious edge when trig is high at reset release); busy=0, glitch_active=0, done=0.
- Reset mid-operation returns immediately to IDLE, and clk_o is passthrough on the next clk.
- Derived strobes:
  - tgt_s = last synchroniser stage.
  - tgt_rise = tgt_s & ~tgt_s_q.
  - tgt_fall = ~tgt_s & tgt_s_q.
  - trig_rise = trig & ~trig_q.
  - A raw tgt_clk edge is visible as a strobe SYNC_STAGES+1 clk later.
- clk_o is a combinational mux of raw tgt_clk:
  - IDLE, ARMED, FINISHED: tgt_clk.
  - INJECT with FAST: clk.
  - INJECT with DROP: 0.
  - INJECT with STRETCH: 1.
  - INJECT with NONE: tgt_clk.
  - RECOVER: 0.
- Configuration is latched on trig_rise and held until IDLE. cfg_* changes during a sequence are ignored.
- IDLE:
  - On trig_rise with cfg_count!=0: latch config, clear counters, go to ARMED.
  - On trig_rise with cfg_count==0: stay in IDLE. No done pulse.
- ARMED, on each tgt_rise:
  - If delay counter == cfg_delay: go to INJECT and clear the length counter.
  - Otherwise increment the delay counter.
  - cfg_delay=0 therefore glitches on the first target edge after the trigger.
- INJECT, FAST/STRETCH/NONE:
  - The length counter increments every clk.
  - When it equals cfg_count-1, go to RECOVER.
  - Exactly cfg_count clk cycles are spent in INJECT.
- INJECT, DROP:
  - When the length counter equals cfg_count-1, go to RECOVER.
  - Otherwise increment it on each tgt_rise.
  - Result: cfg_count target high phases are suppressed, counting the one in which INJECT began.
- RECOVER: hold clk_o=0 until tgt_fall, then go to FINISHED and pulse done for that clk. Passthrough therefore resumes in the target low phase with no runt pulse. If tgt_s is already low, the block waits through a full high phase.
- FINISHED:
  - When trig==0, go to IDLE.
  - A trig that stays high never re-arms.
  - A trig_rise cannot occur in FINISHED without trig first going low.
- If trig_rise and tgt_rise occur in the same clk in IDLE, the block enters ARMED only. That tgt_rise is not counted.
- Counters never wrap: the equality checks terminate them first.

Test Plan:
- FAST, delay=0, count=3, tgt period 20 clk: raise trig → INJECT begins the clk after the first tgt_rise strobe; clk_o shows exactly 3 clk-rate pulses, then 0 until the next tgt_fall; done pulses once; busy is low after it.
- DROP, delay=2, count=2: the first 2 target rising edges after trig pass through. clk_o is then low for exactly 2 target periods, and passthrough resumes in a low phase.
- STRETCH, delay=1, count=5: clk_o is high for exactly 5 clk starting after the 2nd tgt_rise. A low phase follows until tgt_fall, and the output is then clean passthrough.
- cfg_count=0, trig pulsed: stays IDLE; busy, glitch_active and done remain 0; clk_o == tgt_clk throughout.
- FAST count=100, rst asserted for 1 clk mid-INJECT: the next clk has state IDLE, clk_o == tgt_clk, and done does not pulse. A new trig_rise after reset runs a full sequence.
- trig held high across completion: exactly one done pulse and no second glitch over 10 target periods. Drop trig, raise it again: a second sequence runs.
